// File: rtl/serial_bit_sequence_pkg.sv
// serial_bit_sequence_pkg: shared state encodings and sync constants for the
// serial bit sequence encoder/decoder pair. Both ends import the default sync
// pattern from here so they always agree on frame alignment.
`timescale 1ns/1ps
package serial_bit_sequence_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SYNC   = 2'd1,
        ST_DATA   = 2'd2,
        ST_PARITY = 2'd3
    } state_t;

    localparam int DEF_SYNC_WIDTH = 4;
    localparam logic [DEF_SYNC_WIDTH-1:0] DEF_SYNC_PATTERN = 4'b1110;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Counter width able to hold 0..n-1, never below one bit.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/serial_bit_sequence_encoder_bit_period_timer.sv
// bit_period_timer: clock divider that marks the last clock of every serial
// bit period. A start pulse realigns the divider to the first clock of a new
// frame, so bit periods are always measured from the accepting edge.
`timescale 1ns/1ps
module bit_period_timer #(
    parameter int CLKS_PER_BIT = 2
) (
    input  logic clk,
    input  logic n_reset,
    input  logic start,
    output logic bit_tick
);

    localparam int CNT_W = (CLKS_PER_BIT <= 2) ? 1 : $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt;

    // Divider counts 0..CLKS_PER_BIT-1 and restarts at zero on a new frame.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            cnt <= '0;
        end else if (start || (cnt == LAST)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign bit_tick = (cnt == LAST);

endmodule

// File: rtl/serial_bit_sequence_encoder.sv
// serial_bit_sequence_encoder: accepts a parallel word over valid/ready,
// prepends the sync pattern and shifts the frame out MSB-first, each bit held
// CLKS_PER_BIT clocks. Optional even-parity bit after the payload LSB is
// compiled in with macro SERIAL_ENCODER_PARITY_EN.
`timescale 1ns/1ps
module serial_bit_sequence_encoder
    import serial_bit_sequence_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int SYNC_WIDTH = DEF_SYNC_WIDTH,
    parameter logic [SYNC_WIDTH-1:0] SYNC_PATTERN = DEF_SYNC_PATTERN,
    parameter int CLKS_PER_BIT = 2,
    parameter logic IDLE_BIT = 1'b0
) (
    input  logic                  clk,
    input  logic                  n_reset,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  out_bit,
    output logic                  out_active,
    output logic                  frame_done
);

    localparam int IDX_W = idx_width(max_int(SYNC_WIDTH, DATA_WIDTH));
    localparam logic [IDX_W-1:0] SYNC_LAST = IDX_W'(SYNC_WIDTH - 1);
    localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_WIDTH - 1);

    state_t                state;
    logic [DATA_WIDTH-1:0] data_sh;
    logic [SYNC_WIDTH-2:0] sync_sh;   // sync bits still to send after the first
    logic [IDX_W-1:0]      bit_idx;
    logic                  handshake;
    logic                  bit_tick;
`ifdef SERIAL_ENCODER_PARITY_EN
    logic                  parity_bit;
`endif

    assign in_ready  = (state == ST_IDLE);
    assign handshake = in_valid && in_ready;

    bit_period_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_timer (
        .clk     (clk),
        .n_reset (n_reset),
        .start   (handshake),
        .bit_tick(bit_tick)
    );

    // Frame sequencer: latches the word, walks sync/data[/parity] bits and
    // drives the registered serial outputs.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state      <= ST_IDLE;
            out_bit    <= IDLE_BIT;
            out_active <= 1'b0;
            frame_done <= 1'b0;
            data_sh    <= '0;
            sync_sh    <= '0;
            bit_idx    <= '0;
`ifdef SERIAL_ENCODER_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            frame_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        state      <= ST_SYNC;
                        data_sh    <= in_data;
                        sync_sh    <= SYNC_PATTERN[SYNC_WIDTH-2:0];
                        bit_idx    <= '0;
                        out_bit    <= SYNC_PATTERN[SYNC_WIDTH-1];
                        out_active <= 1'b1;
`ifdef SERIAL_ENCODER_PARITY_EN
                        parity_bit <= ^in_data;
`endif
                    end
                end
                ST_SYNC: begin
                    if (bit_tick) begin
                        if (bit_idx == SYNC_LAST) begin
                            state   <= ST_DATA;
                            bit_idx <= '0;
                            out_bit <= data_sh[DATA_WIDTH-1];
                        end else begin
                            bit_idx <= bit_idx + IDX_W'(1);
                            sync_sh <= sync_sh << 1;
                            out_bit <= sync_sh[SYNC_WIDTH-2];
                        end
                    end
                end
                ST_DATA: begin
                    if (bit_tick) begin
                        if (bit_idx == DATA_LAST) begin
                            bit_idx <= '0;
`ifdef SERIAL_ENCODER_PARITY_EN
                            state   <= ST_PARITY;
                            out_bit <= parity_bit;
`else
                            state      <= ST_IDLE;
                            out_bit    <= IDLE_BIT;
                            out_active <= 1'b0;
                            frame_done <= 1'b1;
`endif
                        end else begin
                            bit_idx <= bit_idx + IDX_W'(1);
                            data_sh <= data_sh << 1;
                            out_bit <= data_sh[DATA_WIDTH-2];
                        end
                    end
                end
`ifdef SERIAL_ENCODER_PARITY_EN
                ST_PARITY: begin
                    if (bit_tick) begin
                        state      <= ST_IDLE;
                        out_bit    <= IDLE_BIT;
                        out_active <= 1'b0;
                        frame_done <= 1'b1;
                    end
                end
`endif
                default: begin
                    state      <= ST_IDLE;
                    out_bit    <= IDLE_BIT;
                    out_active <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_bit_sequence_encoder.sv
// Testbench for serial_bit_sequence_encoder: two instances (CLKS_PER_BIT=2 and
// CLKS_PER_BIT=1), randomized words, expected frames queued at handshake and
// checked cycle by cycle by independent monitors. Honors SERIAL_ENCODER_PARITY_EN.
`timescale 1ns/1ps
module tb_serial_bit_sequence_encoder;

    localparam int DW = 8;
    localparam int SW = 4;
    localparam logic [SW-1:0] SYNC = 4'b1110;
`ifdef SERIAL_ENCODER_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int FL = SW + DW + PB;

    typedef struct packed {
        logic [FL-1:0] fr;
        logic          b2b;
    } exp_t;

    logic          clk = 1'b0;
    logic          n_reset = 1'b0;
    logic          vld [2];
    logic [DW-1:0] dat [2];
    logic          rdy [2];
    logic          ob  [2];
    logic          oa  [2];
    logic          fd  [2];

    int   checks = 0;
    int   failures = 0;
    exp_t q0[$];
    exp_t q1[$];

    always #5 clk = ~clk;

    serial_bit_sequence_encoder #(.CLKS_PER_BIT(2)) dut0 (
        .clk(clk), .n_reset(n_reset), .in_data(dat[0]), .in_valid(vld[0]),
        .in_ready(rdy[0]), .out_bit(ob[0]), .out_active(oa[0]), .frame_done(fd[0])
    );

    serial_bit_sequence_encoder #(.CLKS_PER_BIT(1)) dut1 (
        .clk(clk), .n_reset(n_reset), .in_data(dat[1]), .in_valid(vld[1]),
        .in_ready(rdy[1]), .out_bit(ob[1]), .out_active(oa[1]), .frame_done(fd[1])
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference frame: sync pattern, payload MSB-first, optional even parity.
    function automatic logic [FL-1:0] frame_of(input logic [DW-1:0] w);
        logic [SW+DW:0] full;
        full = {SYNC, w, ^w};
        if (PB == 1) return full[FL-1:0];
        else         return full[SW+DW:1];
    endfunction

    task automatic send(input int id, input logic [DW-1:0] word, input bit keep);
        bit   waited = 1'b0;
        bit   done = 1'b0;
        exp_t e;
        vld[id] = 1'b1;
        dat[id] = word;
        for (int n = 0; n < 400 && !done; n++) begin
            @(negedge clk);
            if (rdy[id]) begin
                e.fr  = frame_of(word);
                e.b2b = waited;
                if (id == 0) q0.push_back(e);
                else         q1.push_back(e);
                @(posedge clk);
                #1;
                vld[id] = keep;
                dat[id] = DW'($urandom);
                done = 1'b1;
            end else begin
                waited = 1'b1;
            end
        end
        if (!done) begin
            chk("handshake_timeout", int'(done), 1);
            vld[id] = 1'b0;
        end
    endtask

    task automatic monitor(input int id, input int cpb);
        exp_t e;
        int   cyc = 0;
        int   fd_cyc = -100;
        bit   aborted;
        bit   have;
        forever begin
            @(negedge clk);
            cyc++;
            if (!n_reset) begin
                chk("rst_out_bit", int'(ob[id]), 0);
                chk("rst_out_active", int'(oa[id]), 0);
                chk("rst_in_ready", int'(rdy[id]), 1);
                chk("rst_frame_done", int'(fd[id]), 0);
            end else if (oa[id]) begin
                have = (id == 0) ? (q0.size() != 0) : (q1.size() != 0);
                chk("frame_expected", int'(have), 1);
                if (have) begin
                    if (id == 0) e = q0.pop_front();
                    else         e = q1.pop_front();
                    if (e.b2b) chk("b2b_gap", cyc - fd_cyc, 1);
                    aborted = 1'b0;
                    for (int i = 0; i < FL * cpb; i++) begin
                        if (i > 0) begin
                            @(negedge clk);
                            cyc++;
                        end
                        if (!n_reset) begin
                            aborted = 1'b1;
                            break;
                        end
                        chk("frame_bit", int'(ob[id]), int'(e.fr[FL-1-(i/cpb)]));
                        chk("frame_active", int'(oa[id]), 1);
                        chk("frame_ready_low", int'(rdy[id]), 0);
                        chk("frame_done_early", int'(fd[id]), 0);
                    end
                    if (!aborted) begin
                        @(negedge clk);
                        cyc++;
                        if (n_reset) begin
                            chk("end_frame_done", int'(fd[id]), 1);
                            chk("end_active", int'(oa[id]), 0);
                            chk("end_out_bit", int'(ob[id]), 0);
                            chk("end_ready", int'(rdy[id]), 1);
                            fd_cyc = cyc;
                        end
                    end
                end
            end else begin
                chk("idle_out_bit", int'(ob[id]), 0);
                chk("idle_frame_done", int'(fd[id]), 0);
                chk("idle_ready", int'(rdy[id]), 1);
            end
        end
    endtask

    task automatic rand_stream(input int id);
        bit keep;
        for (int k = 0; k < 15; k++) begin
            keep = (k == 14) ? 1'b0 : 1'($urandom_range(0, 1));
            send(id, DW'($urandom), keep);
            if (!keep) begin
                repeat ($urandom_range(0, 4)) @(posedge clk);
                #1;
            end
        end
    endtask

    initial monitor(0, 2);
    initial monitor(1, 1);

    initial begin
        vld[0] = 1'b0; vld[1] = 1'b0;
        dat[0] = '0;   dat[1] = '0;
        n_reset = 1'b0;
        #44002;
        n_reset = 1'b1;
        @(posedge clk);
        #1;

        // A5 with valid held into a pending 3C, then a parity-1 word
        send(0, 8'hA5, 1'b1);
        send(0, 8'h3C, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        send(0, 8'h07, 1'b0);

        // Reset mid-frame after five bits, then a full fresh frame
        send(0, 8'hA5, 1'b0);
        repeat (10) @(posedge clk);
        #3;
        n_reset = 1'b0;
        #1;
        chk("async_rst_out_bit", int'(ob[0]), 0);
        chk("async_rst_ready", int'(rdy[0]), 1);
        chk("async_rst_active", int'(oa[0]), 0);
        @(posedge clk);
        #2;
        n_reset = 1'b1;
        @(posedge clk);
        #1;
        send(0, 8'h5A, 1'b0);

        // Single-clock bit periods, back-to-back words
        send(1, 8'hC3, 1'b1);
        send(1, 8'h81, 1'b0);

        fork
            rand_stream(0);
            rand_stream(1);
        join

        repeat (80) @(negedge clk);
        chk("q0_drained", q0.size(), 0);
        chk("q1_drained", q1.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serial_bit_sequence_encoder.md
Name: serial_bit_sequence_encoder

Overview:
- Upstream stage of serial_bit_sequence_decoder; produces the serial bit stream that drives the decoder's in_bit.
- Accepts a parallel word over a valid/ready handshake and prepends a fixed sync pattern.
- Shifts the frame out MSB-first, holding each bit for a programmable number of clocks.
- Single clock domain; decoder and encoder share clk and n_reset.

Parameters:
- DATA_WIDTH, 8, payload bits per frame.
- SYNC_WIDTH, 4, sync pattern length in bits.
- SYNC_PATTERN, 4'b1110, sync bits sent MSB-first before the payload.
- CLKS_PER_BIT, 2, clocks each serial bit is held (>=1).
- IDLE_BIT, 1'b0, out_bit level between frames.

Ports:
- clk  input  1  system clock, rising edge.
- n_reset  input  1  asynchronous active-low reset.
- in_data  input  DATA_WIDTH  payload word, sampled on handshake.
- in_valid  input  1  in_data valid.
- in_ready  output  1  encoder can accept a word (state IDLE).
- out_bit  output  1  serial stream to decoder in_bit, registered.
- out_active  output  1  high while a frame bit is on out_bit, registered.
- frame_done  output  1  one-cycle pulse after the final bit period, registered.

Behaviour:
Reset state (async, n_reset low):
- state=IDLE, out_bit=IDLE_BIT, out_active=0, frame_done=0, in_ready=1.
- All counters and the shift register are cleared.
- Reset mid-frame aborts the frame immediately; no partial frame resumes.

State IDLE:
- in_ready=1 (decoded from state).
- Handshake = in_valid && in_ready at a rising edge.
- On handshake at edge k: in_data is latched into the shift register, state goes to SYNC, out_bit=SYNC_PATTERN[SYNC_WIDTH-1], and out_active=1, all taking effect from edge k.

State SYNC:
- Each bit is held exactly CLKS_PER_BIT clocks, timed by a clock divider (0..CLKS_PER_BIT-1).
- Sends SYNC_WIDTH bits MSB-first, then goes to DATA.

State DATA:
- Sends DATA_WIDTH latched bits, MSB first.
- After the LSB period, goes to PARITY if compiled in, otherwise to IDLE.

Frame end:
- On the edge ending the last bit period: state=IDLE, out_bit=IDLE_BIT, out_active=0, frame_done=1 for exactly one cycle.

Handshake and timing rules:
- in_ready=0 in every non-IDLE state. in_valid during a frame is ignored; the word is held off, not dropped.
- Changes to in_data after the handshake have no effect.
- Back-to-back frames: a word can be accepted in the frame_done cycle, giving a minimum gap of one clock of IDLE_BIT.
- Frame length is (SYNC_WIDTH+DATA_WIDTH[+1])*CLKS_PER_BIT clocks.
- Bit index counters are sized $clog2 of max(SYNC_WIDTH, DATA_WIDTH) and never wrap mid-state.

Optional Feature:
- Macro SERIAL_ENCODER_PARITY_EN.
- Defined: PARITY state adds one bit after the data LSB, equal to even parity (XOR of the latched payload), held CLKS_PER_BIT clocks.
- Undefined: no PARITY state; DATA goes straight to IDLE. Port list is identical in both builds.

Decomposition:
- Package serial_bit_sequence_pkg holds:
  - state encodings ST_IDLE, ST_SYNC, ST_DATA, ST_PARITY;
  - default SYNC_PATTERN/SYNC_WIDTH constants, shared with the decoder so both agree on sync.
- One sub-module, bit_period_timer:
  - parameter CLKS_PER_BIT; inputs clk, n_reset, start;
  - output bit_tick, asserted on the last clock of each bit period.

Test Plan:
1. Hold n_reset low 44us, then release -> out_bit=0, out_active=0, in_ready=1, frame_done=0 throughout reset.
2. Defaults, in_data=8'hA5 handshake -> out_bit 1,1,1,0,1,0,1,0,0,1,0,1, each for 2 clocks; out_active high 24 clocks; in_ready low 24 clocks; single frame_done pulse.
3. Hold in_valid=1 with 8'h3C during the 8'hA5 frame, changing in_data mid-frame -> 8'hA5 frame unaltered; 8'h3C accepted in the frame_done cycle; one idle clock gap.
4. Assert n_reset low after 5 bits of a frame -> out_bit=0 and in_ready=1 immediately (asynchronously); the next frame starts with the full 1110 sync.
5. SERIAL_ENCODER_PARITY_EN defined: 8'hA5 -> parity bit 0, 8'h07 -> parity bit 1; each frame is 13 bits / 26 clocks.
6. CLKS_PER_BIT=1, in_valid held high with two words -> two 12-clock frames separated by exactly one IDLE_BIT clock.
